// File: rtl/matrix_mult_pkg.sv
// matrix_mult_pkg
// Shared definitions for the streaming matrix multiplier:
//   - state_t      : 3-bit controller state encoding
//   - clog2/idx_w  : elaboration-time width helpers
//   - DEF_*        : default operand width and matrix dimensions
package matrix_mult_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_M  = 4;
  localparam int DEF_K  = 4;
  localparam int DEF_N  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width for an array of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mult_stream_mac_unit.sv
// mac_unit
// One multiply-accumulate step per enabled cycle.
//   i_en        : update the accumulator register with o_sum
//   i_seed_load : start a new dot product from i_seed instead of the accumulator
//   i_seed      : starting value (previous C element or zero)
//   i_a, i_b    : operands, two's complement when SIGNED != 0
//   o_sum       : base + extended product, available in the same cycle so the
//                 caller can write the finished element without an extra cycle
module mac_unit #(
  parameter int DW     = 8,
  parameter int AW     = 18,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_seed_load,
  input  logic [AW-1:0] i_seed,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [AW-1:0] o_sum
);

  logic [2*DW-1:0] w_prod;
  logic [AW-1:0]   w_prod_ext;
  logic [AW-1:0]   w_base;
  logic [AW-1:0]   r_acc;

  generate
    if (SIGNED != 0) begin : g_signed
      assign w_prod     = $signed({{DW{i_a[DW-1]}}, i_a}) * $signed({{DW{i_b[DW-1]}}, i_b});
      // Size cast of a signed expression sign-extends, and stays legal when AW == 2*DW.
      assign w_prod_ext = AW'($signed(w_prod));
    end else begin : g_unsigned
      assign w_prod     = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
      assign w_prod_ext = AW'(w_prod);
    end
  endgenerate

  assign w_base = i_seed_load ? i_seed : r_acc;
  assign o_sum  = w_base + w_prod_ext;  // wraps modulo 2^AW

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/matrix_mult_stream.sv
// matrix_mult_stream
// Streaming C = A x B (mode 0) or C = C + A x B (mode 1); A is MxK, B is KxN.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, mode         : job request and mode, sampled only in IDLE
//   in_valid/in_ready   : operand stream (A row-major, then B row-major)
//   in_data             : operand element
//   out_valid/out_ready : result stream of C, row-major
//   out_data            : C element (zero when not valid)
//   busy                : high in every state except IDLE
//   done                : one-cycle pulse in the cycle after the last output
//   dbg_state           : current controller state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds data stable while valid is high and ready is low.
module matrix_mult_stream
  import matrix_mult_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int M      = DEF_M,
  parameter int K      = DEF_K,
  parameter int N      = DEF_N,
  parameter int SIGNED = 0,
  parameter int AW     = 2*DW + clog2(K)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output state_t        dbg_state
);

  localparam int NA  = M*K;
  localparam int NB  = K*N;
  localparam int NC  = M*N;
  localparam int AAW = idx_w(NA);
  localparam int BAW = idx_w(NB);
  localparam int CAW = idx_w(NC);
  localparam int LW  = idx_w((NA > NB) ? NA : NB);
  localparam int IW  = idx_w(M);
  localparam int JW  = idx_w(N);
  localparam int KW  = idx_w(K);

  state_t         r_state, w_state_nxt;
  logic           r_mode, r_c_valid, r_done;
  logic [LW-1:0]  r_ld_cnt;
  logic [IW-1:0]  r_i;
  logic [JW-1:0]  r_j;
  logic [KW-1:0]  r_k;
  logic [CAW-1:0] r_idx;

  logic [DW-1:0]  r_a [NA];
  logic [DW-1:0]  r_b [NB];
  logic [AW-1:0]  r_c [NC];

  logic           w_accept, w_ld_last_a, w_ld_last_b;
  logic           w_k_last, w_j_last, w_i_last, w_mac_last;
  logic           w_out_fire, w_out_last;
  logic [AAW-1:0] w_a_addr;
  logic [BAW-1:0] w_b_addr;
  logic [CAW-1:0] w_c_addr;
  logic [AW-1:0]  w_seed, w_mac_sum;

  assign in_ready  = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign out_valid = (r_state == ST_OUTPUT);
  assign out_data  = out_valid ? r_c[r_idx] : '0;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

  assign w_accept    = in_valid && ((r_state == ST_LOAD_A) || (r_state == ST_LOAD_B));
  assign w_ld_last_a = (int'(r_ld_cnt) == NA-1);
  assign w_ld_last_b = (int'(r_ld_cnt) == NB-1);
  assign w_k_last    = (int'(r_k) == K-1);
  assign w_j_last    = (int'(r_j) == N-1);
  assign w_i_last    = (int'(r_i) == M-1);
  assign w_mac_last  = w_k_last && w_j_last && w_i_last;
  assign w_out_fire  = out_ready && (r_state == ST_OUTPUT);
  assign w_out_last  = (int'(r_idx) == NC-1);

  assign w_a_addr = AAW'(int'(r_i)*K + int'(r_k));
  assign w_b_addr = BAW'(int'(r_k)*N + int'(r_j));
  assign w_c_addr = CAW'(int'(r_i)*N + int'(r_j));

  // Accumulate mode seeds each dot product with the previous C element.
  assign w_seed = r_mode ? r_c[w_c_addr] : '0;

  mac_unit #(
    .DW     (DW),
    .AW     (AW),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk         (clk),
    .reset       (reset),
    .i_en        (r_state == ST_COMPUTE),
    .i_seed_load (r_k == '0),
    .i_seed      (w_seed),
    .i_a         (r_a[w_a_addr]),
    .i_b         (r_b[w_b_addr]),
    .o_sum       (w_mac_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = ST_LOAD_A;
      ST_LOAD_A:  if (w_accept && w_ld_last_a) w_state_nxt = ST_LOAD_B;
      ST_LOAD_B:  if (w_accept && w_ld_last_b) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (w_mac_last) w_state_nxt = ST_OUTPUT;
      ST_OUTPUT:  if (w_out_fire && w_out_last) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mode    <= 1'b0;
      r_c_valid <= 1'b0;
      r_done    <= 1'b0;
      r_ld_cnt  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_idx     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Accumulating onto a C that was never computed falls back to mode 0.
            r_mode   <= mode && r_c_valid;
            r_ld_cnt <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_idx    <= '0;
          end
        end
        ST_LOAD_A: begin
          if (w_accept) r_ld_cnt <= w_ld_last_a ? '0 : r_ld_cnt + LW'(1);
        end
        ST_LOAD_B: begin
          if (w_accept) r_ld_cnt <= w_ld_last_b ? '0 : r_ld_cnt + LW'(1);
        end
        ST_COMPUTE: begin
          if (w_k_last) begin
            r_k <= '0;
            if (w_j_last) begin
              r_j <= '0;
              r_i <= w_i_last ? '0 : r_i + IW'(1);
            end else begin
              r_j <= r_j + JW'(1);
            end
          end else begin
            r_k <= r_k + KW'(1);
          end
          if (w_mac_last) r_c_valid <= 1'b1;
        end
        ST_OUTPUT: begin
          if (w_out_fire) begin
            if (w_out_last) begin
              r_idx  <= '0;
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + CAW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and result storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if ((r_state == ST_LOAD_A) && w_accept) r_a[AAW'(r_ld_cnt)] <= in_data;
    if ((r_state == ST_LOAD_B) && w_accept) r_b[BAW'(r_ld_cnt)] <= in_data;
    if ((r_state == ST_COMPUTE) && w_k_last) r_c[w_c_addr] <= w_mac_sum;
  end

endmodule

// File: tb/tb_matrix_mult_stream.sv
// tb_matrix_mult_stream
// Drives an unsigned and a signed 4x4x4 instance from the same stimulus and
// checks each output stream against hand-computed expected queues.
module tb_matrix_mult_stream;
  import matrix_mult_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 18;
  localparam int LAT = 1 + 16 + 16 + 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;

  logic          in_ready_u, out_valid_u, busy_u, done_u;
  logic [AW-1:0] out_data_u;
  state_t        st_u;
  logic          in_ready_s, out_valid_s, busy_s, done_s;
  logic [AW-1:0] out_data_s;
  state_t        st_s;

  matrix_mult_stream #(.SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_u),
    .out_valid(out_valid_u), .out_data(out_data_u), .out_ready(out_ready),
    .busy(busy_u), .done(done_u), .dbg_state(st_u)
  );

  matrix_mult_stream #(.SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
    .busy(busy_s), .done(done_s), .dbg_state(st_s)
  );

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_q_u[$];
  logic [AW-1:0] exp_q_s[$];
  logic [AW-1:0] exp_u[16];
  logic [AW-1:0] exp_s[16];
  logic [DW-1:0] mat_a[16];
  logic [DW-1:0] mat_b[16];
  int done_cnt_u = 0;
  int done_cnt_s = 0;
  bit bp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- output backpressure driver ----------------
  logic bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int   bp_ph = 0;
  always @(posedge clk) begin
    #1;
    if (bp_on) begin
      out_ready = bp_pat[bp_ph];
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  // ---------------- monitors ----------------
  logic          stall_u = 1'b0, stall_s = 1'b0;
  logic [AW-1:0] hold_u, hold_s;

  always @(negedge clk) begin
    if (reset) begin
      stall_u = 1'b0;
    end else begin
      if (done_u) done_cnt_u++;
      if (stall_u) begin
        chk("hold_valid_u", 32'(out_valid_u), 32'd1);
        chk("hold_data_u", 32'(out_data_u), 32'(hold_u));
      end
      if (out_valid_u && out_ready) begin
        if (exp_q_u.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL extra_out_u: got 0x%0h expected none", out_data_u);
        end else begin
          chk("out_u", 32'(out_data_u), 32'(exp_q_u.pop_front()));
        end
      end
      stall_u = out_valid_u && !out_ready;
      hold_u  = out_data_u;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_s = 1'b0;
    end else begin
      if (done_s) done_cnt_s++;
      if (stall_s) begin
        chk("hold_valid_s", 32'(out_valid_s), 32'd1);
        chk("hold_data_s", 32'(out_data_s), 32'(hold_s));
      end
      if (out_valid_s && out_ready) begin
        if (exp_q_s.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL extra_out_s: got 0x%0h expected none", out_data_s);
        end else begin
          chk("out_s", 32'(out_data_s), 32'(exp_q_s.pop_front()));
        end
      end
      stall_s = out_valid_s && !out_ready;
      hold_s  = out_data_s;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DW-1:0] elem(input int idx);
    return (idx < 16) ? mat_a[idx] : mat_b[idx-16];
  endfunction

  task automatic set_identity();
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = ((i / 4) == (i % 4)) ? 8'd1 : 8'd0;
      mat_b[i] = 8'(i + 1);
    end
  endtask

  task automatic set_exp_scaled(input int scale);
    for (int i = 0; i < 16; i++) begin
      exp_u[i] = AW'((i + 1) * scale);
      exp_s[i] = AW'((i + 1) * scale);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // abort_at > 0: reset after that many accepted elements, no outputs expected.
  task automatic run_job(input bit m, input bit gaps, input bit chk_lat,
                         input int abort_at, input bit poke_start);
    int idx, lat, cyc, t, n_feed;
    bit rdy;
    n_feed = (abort_at > 0) ? abort_at : 32;
    if (abort_at == 0) begin
      for (int i = 0; i < 16; i++) begin
        exp_q_u.push_back(exp_u[i]);
        exp_q_s.push_back(exp_s[i]);
      end
    end
    done_cnt_u = 0;
    done_cnt_s = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    idx = 0; lat = 0; cyc = 0;
    while (idx < n_feed && cyc < 400) begin
      in_valid = !(gaps && (cyc % 3 == 2));
      in_data  = elem(idx);
      rdy      = in_ready_u;
      @(posedge clk);
      lat++;
      if (in_valid && rdy) idx++;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    chk("feed_count", 32'(idx), 32'(n_feed));

    if (abort_at > 0) begin
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy_u", 32'(busy_u), 32'd0);
      chk("abort_in_ready_u", 32'(in_ready_u), 32'd0);
      chk("abort_done_u", 32'(done_u), 32'd0);
      chk("abort_busy_s", 32'(busy_s), 32'd0);
      chk("abort_state_u", 32'(st_u), 32'(ST_IDLE));
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_done_u", 32'(done_cnt_u), 32'd0);
      chk("abort_idle_u", 32'(busy_u), 32'd0);
      return;
    end

    t = 0;
    while (!out_valid_u && t < 300) begin
      start = poke_start && (t == 10);
      @(posedge clk);
      lat++;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    chk("first_valid_seen", 32'(out_valid_u), 32'd1);
    if (chk_lat) chk("latency", 32'(lat), 32'(LAT));

    t = 0;
    while ((exp_q_u.size() != 0 || exp_q_s.size() != 0 || busy_u || busy_s) && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("drain_u", 32'(exp_q_u.size()), 32'd0);
    chk("drain_s", 32'(exp_q_s.size()), 32'd0);
    @(negedge clk);
    chk("done_pulses_u", 32'(done_cnt_u), 32'd1);
    chk("done_pulses_s", 32'(done_cnt_s), 32'd1);
    chk("idle_after_u", 32'(busy_u), 32'd0);
    chk("idle_after_s", 32'(busy_s), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_u", 32'(busy_u), 32'd0);
    chk("rst_in_ready_u", 32'(in_ready_u), 32'd0);
    chk("rst_out_valid_u", 32'(out_valid_u), 32'd0);
    chk("rst_out_data_u", 32'(out_data_u), 32'd0);
    chk("rst_done_u", 32'(done_u), 32'd0);
    chk("rst_state_u", 32'(st_u), 32'(ST_IDLE));
    chk("rst_busy_s", 32'(busy_s), 32'd0);
    chk("rst_out_valid_s", 32'(out_valid_s), 32'd0);
    reset = 1'b0;

    // Identity A times B = 1..16.
    set_identity();
    set_exp_scaled(1);
    run_job(1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Same operands accumulated onto the previous C.
    set_exp_scaled(2);
    run_job(1'b1, 1'b0, 1'b1, 0, 1'b0);

    // After reset, accumulate request degrades to plain multiply.
    pulse_reset();
    set_exp_scaled(1);
    run_job(1'b1, 1'b0, 1'b1, 0, 1'b0);

    // A all 0xFF, B all 0x02: unsigned 4*255*2 = 0x7F8, signed 4*(-2) = -8.
    for (int i = 0; i < 16; i++) begin
      mat_a[i] = 8'hFF;
      mat_b[i] = 8'h02;
      exp_u[i] = 18'h007F8;
      exp_s[i] = 18'h3FFF8;
    end
    run_job(1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Input gaps and output backpressure.
    set_identity();
    set_exp_scaled(1);
    bp_on = 1'b1;
    run_job(1'b0, 1'b1, 1'b0, 0, 1'b0);
    bp_on = 1'b0;
    @(negedge clk);

    // Abort after 16 A + 5 B elements, then a fresh job; reset cleared C.
    run_job(1'b0, 1'b0, 1'b0, 21, 1'b0);
    set_exp_scaled(1);
    run_job(1'b1, 1'b0, 1'b1, 0, 1'b0);

    // start pulsed during COMPUTE is ignored.
    run_job(1'b0, 1'b0, 1'b1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
